wu_tdc_capture: RTL and testbench
=================================

WU_TDC_CAPTURE -- requirements
Module: wu_tdc_capture

Interface
REQ-001 The block SHALL have parameter TAPS, default 56, giving the number of delay-line taps; it must be a multiple of 4.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the coarse counter width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the output FIFO depth; it must be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter DEAD_CYC, default 4, giving the number of cycles after a hit during which new hits are ignored; it must be at least 1.
REQ-005 The block SHALL define local FINE_W = clog2(TAPS+1) and local W = CNT_W+FINE_W.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 Port en, input, 1 bit: measurement enable.
REQ-009 Port taps, input, TAPS bits: raw CARRY4 delay-line outputs, asynchronous; bit 0 is the chain entry.
REQ-010 Port m_data, output, W bits: event word, with the coarse value in the upper CNT_W bits and the fine value in the lower FINE_W bits.
REQ-011 Port m_valid, output, 1 bit: m_data is valid.
REQ-012 Port m_ready, input, 1 bit: the consumer accepts the word.
REQ-013 Port ovf, output, 1 bit: sticky flag indicating an event was dropped.
REQ-014 Port busy, output, 1 bit: high while the FSM is not in IDLE or ARMED.

Function
REQ-015 Capture: taps SHALL be registered every cycle into q1, then q1 into q2; q1 is the metastability sample point, and no logic other than q2 SHALL read q1.
REQ-016 Coarse counter: CNT_W bits, incremented every cycle while en=1, wrapping from 2^CNT_W-1 to 0; it SHALL hold at 0 while en=0.
REQ-017 The coarse value delayed to align with q2 SHALL be stored as c2.
REQ-018 Hit detect: a hit SHALL be declared in the cycle where q2[0]=1 and the previous q2[0]=0, qualified by the FSM being in ARMED.
REQ-019 Fine code: popcount(q2) at the hit cycle, range 0..TAPS, registered one cycle later together with c2.
REQ-020 FSM IDLE: entered on reset or when en=0; transitions to ARMED when en=1 and q2[0]=0.
REQ-021 FSM ARMED: on a detected hit, transitions to ENCODE.
REQ-022 FSM ENCODE: lasts 1 cycle; the FIFO write is issued; transitions to DEAD.
REQ-023 FSM DEAD: counts DEAD_CYC cycles, then transitions to ARMED if q2[0]=0; otherwise it waits in DEAD until q2[0]=0.
REQ-024 en=0 SHALL force IDLE from any state on the next edge; any ENCODE write in that same cycle still completes.
REQ-025 Latency: from the clock edge at which taps is sampled into q1 (capture edge E) to the FIFO write SHALL be edge E+3.
REQ-026 On an empty FIFO, m_valid SHALL rise after edge E+3, with coarse equal to the counter value at edge E.
REQ-027 FIFO: DEPTH entries, first-in first-out.
REQ-028 m_valid SHALL equal "not empty"; m_data SHALL be the head entry and SHALL hold stable while m_valid=1 and m_ready=0.
REQ-029 Pop SHALL occur on m_valid and m_ready.
REQ-030 A write while full and not popping SHALL drop the word and set ovf.
REQ-031 A write while full with a simultaneous pop SHALL be accepted.
REQ-032 A simultaneous push and pop on an empty FIFO SHALL leave the word written, with m_valid next cycle.
REQ-033 ovf SHALL clear only on reset or on en=0.
REQ-034 The FIFO contents SHALL be retained while en=0, and draining SHALL continue.
REQ-035 Hits arriving while the FSM is in IDLE, ENCODE or DEAD SHALL be ignored silently and SHALL NOT set ovf.
REQ-036 Coarse wrap SHALL NOT be flagged; the consumer unwraps it.

Reset
REQ-037 On rst_n=0 at a clock edge, the following SHALL be cleared: q1, q2, c2, the coarse counter and the FIFO pointers.
REQ-038 On rst_n=0 at a clock edge: FSM=IDLE, m_valid=0, m_data=0, ovf=0, busy=0.
REQ-039 A reset asserted mid-ENCODE or mid-DEAD SHALL discard the pending event with no partial write.
REQ-040 After release, the block SHALL require en=1 and q2[0]=0 before arming.

Verification
REQ-041 Scenario 1: TAPS=56; reset, en=1; hold taps=0 for 10 cycles, then at capture edge E drive taps with bits 0..22 set, then all ones -> one word, fine=23, coarse=counter(E), m_valid high after E+3, m_ready=1 pops it.
REQ-042 Scenario 2: bubble pattern taps=56'h...0F7 (bits 0-2, 4-7 set), all else 0 -> fine=7; all ones -> fine=56; first tap only -> fine=1.
REQ-043 Scenario 3: m_ready=0, DEPTH=4, DEAD_CYC=4; 5 hits spaced 8 cycles -> 4 words held in order, the 5th dropped, ovf=1, m_data stable; then en=0 -> ovf=0, the 4 words still drain.
REQ-044 Scenario 4: second rising edge at q2[0] 2 cycles after the first hit (within DEAD) -> no second word; a rising edge after DEAD plus a low q2[0] -> word accepted.
REQ-045 Scenario 5: CNT_W=4; hits at counter values 14 and 2 (post-wrap) -> coarse 14 then 2; a full-FIFO push with a simultaneous pop -> accepted, no ovf.
REQ-046 Scenario 6: rst_n=0 one cycle after a hit is detected (in ENCODE) -> m_valid stays 0, FSM=IDLE, coarse=0; taps held high after release -> no arm until taps go low.

Source files
------------

// File: rtl/wu_tdc_capture.sv
// -----------------------------------------------------------------------------
// wu_tdc_capture
// Wave-union style TDC front end. A CARRY4 delay line (taps) is double-flopped,
// a rising edge on the chain entry marks a hit, and the hit is encoded as
// {coarse counter, popcount of the tap word} into a small output FIFO.
//
// Ports
//   clk      : single clock
//   rst_n    : synchronous active-low reset
//   en       : measurement enable (low forces IDLE, zeroes the counter, clears ovf)
//   taps     : raw asynchronous delay-line outputs, bit 0 = chain entry
//   m_data   : event word {coarse[CNT_W-1:0], fine[FINE_W-1:0]}, 0 when empty
//   m_valid  : FIFO not empty
//   m_ready  : consumer accepts head word
//   ovf      : sticky, an event was dropped because the FIFO was full
//   busy     : FSM is in ENCODE or DEAD
// -----------------------------------------------------------------------------
module wu_tdc_capture #(
    parameter int TAPS     = 56,
    parameter int CNT_W    = 16,
    parameter int DEPTH    = 4,
    parameter int DEAD_CYC = 4,
    localparam int FINE_W  = $clog2(TAPS + 1),
    localparam int W       = CNT_W + FINE_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [TAPS-1:0] taps,
    output logic [W-1:0]    m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            ovf,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CYC - 1);

    typedef enum logic [1:0] {IDLE, ARMED, ENCODE, DEAD} state_t;

    function automatic logic [FINE_W-1:0] popcnt(input logic [TAPS-1:0] v);
        logic [FINE_W-1:0] s;
        s = '0;
        for (int i = 0; i < TAPS; i++) s = s + FINE_W'(v[i]);
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Capture pipeline and coarse counter
    // ------------------------------------------------------------------
    logic [TAPS-1:0]  q1, q2;
    logic             q2_0_d;
    logic [1:0]       vld_pipe;   // q1 / q2 hold a real post-reset sample
    logic [CNT_W-1:0] cnt, c1, c2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1       <= '0;
            q2       <= '0;
            q2_0_d   <= 1'b0;
            vld_pipe <= '0;
            cnt      <= '0;
            c1       <= '0;
            c2       <= '0;
        end else begin
            q1       <= taps;     // metastability sample point, read only by q2
            q2       <= q1;
            q2_0_d   <= q2[0];
            vld_pipe <= {vld_pipe[0], 1'b1};
            cnt      <= en ? cnt + CNT_ONE : '0;
            c1       <= cnt;      // counter value at the capture edge
            c2       <= c1;       // aligned with q2
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t            state, state_nx;
    logic [DW-1:0]     dcnt;
    logic [FINE_W-1:0] fine_r;
    logic [CNT_W-1:0]  coarse_r;
    logic              hit;
    logic              wr_en;

    assign hit   = (state == ARMED) && q2[0] && !q2_0_d;
    assign wr_en = (state == ENCODE);
    assign busy  = (state == ENCODE) || (state == DEAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dcnt     <= '0;
            fine_r   <= '0;
            coarse_r <= '0;
        end else begin
            state <= state_nx;
            if (state == ENCODE)
                dcnt <= '0;
            else if (state == DEAD && dcnt != DEAD_LAST)
                dcnt <= dcnt + DW'(1);
            if (hit) begin
                fine_r   <= popcnt(q2);
                coarse_r <= c2;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            // Arm only on a genuine low sample; the zeros left by reset do not count.
            IDLE:   if (en && vld_pipe[1] && !q2[0]) state_nx = ARMED;
            ARMED:  if (hit) state_nx = ENCODE;
            ENCODE: state_nx = DEAD;
            DEAD:   if (dcnt == DEAD_LAST && !q2[0]) state_nx = ARMED;
            default: state_nx = IDLE;
        endcase
        if (!en) state_nx = IDLE;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         empty, full, push, pop, drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = m_valid && m_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push  = wr_en && (!full || pop);
    assign drop  = wr_en && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= {coarse_r, fine_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            if (!en)
                ovf <= 1'b0;
            else if (drop)
                ovf <= 1'b1;
        end
    end

    assign m_valid = !empty;
    assign m_data  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_wu_tdc_capture.sv
// -----------------------------------------------------------------------------
// tb_wu_tdc_capture
// Directed scenarios followed by randomized taps / m_ready / en traffic.
// A reference model (sample history + timing rules + FIFO occupancy) predicts
// each event word and pushes it into a scoreboard; an independent monitor
// compares every presented head word against the scoreboard.
// -----------------------------------------------------------------------------
module tb_wu_tdc_capture;

    localparam int TAPS     = 56;
    localparam int CNT_W    = 4;
    localparam int DEPTH    = 4;
    localparam int DEAD_CYC = 4;
    localparam int FINE_W   = $clog2(TAPS + 1);
    localparam int W        = CNT_W + FINE_W;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [TAPS-1:0] taps;
    logic [W-1:0]    m_data;
    logic            m_valid;
    logic            m_ready;
    logic            ovf;
    logic            busy;

    wu_tdc_capture #(
        .TAPS(TAPS), .CNT_W(CNT_W), .DEPTH(DEPTH), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .taps(taps),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ovf(ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Runs on the falling edge, predicting the effect of
    // the upcoming rising edge n from the inputs now being presented.
    // Rules: a rising edge of taps[0] between samples m-1 and m is taken when
    // the block is armed, en is still high two edges later, and m is at least
    // DEAD_CYC+2 samples after the previous taken edge. Arming needs en high
    // and a real (post-reset) low sample. The word lands in the FIFO 3 edges
    // after the capture edge.
    // ------------------------------------------------------------------
    typedef struct {
        int           edge_n;
        logic [W-1:0] word;
    } pend_t;

    int           b0_h[int];   // taps[0] per capture edge; 2 = not a real sample
    int           pc_h[int];
    int           cv_h[int];
    pend_t        pend_q[$];
    logic [W-1:0] sb_q[$];
    logic [W-1:0] popped[$];
    int           n_edge   = 0;
    int           mcnt     = 0;
    int           arm_edge = -1;
    int           last_acc = -1000;
    int           mcount   = 0;
    bit           movf     = 0;
    bit           seen_rst = 0;

    function automatic int b0(input int i);
        return b0_h.exists(i) ? b0_h[i] : 2;
    endfunction

    always @(negedge clk) begin
        int  n, m;
        bit  mpop;
        pend_t p;
        n = n_edge;
        if (seen_rst) begin
            chk("m_valid", m_valid, (mcount > 0));
            chk("ovf", ovf, movf);
        end
        if (!rst_n) begin
            mcnt     = 0;
            arm_edge = -1;
            last_acc = -1000;
            mcount   = 0;
            movf     = 0;
            pend_q.delete();
            sb_q.delete();
            b0_h[n]   = 2;
            b0_h[n-1] = 2;
            seen_rst  = 1;
        end else begin
            b0_h[n] = int'(taps[0]);
            pc_h[n] = $countones(taps);
            cv_h[n] = mcnt;
            mpop = (mcount > 0) && m_ready;
            if (pend_q.size() > 0 && pend_q[0].edge_n == n) begin
                if (mcount == DEPTH && !mpop)
                    movf = 1;
                else begin
                    mcount++;
                    sb_q.push_back(pend_q[0].word);
                end
                void'(pend_q.pop_front());
            end
            if (mpop) mcount--;
            m = n - 2;
            if (en && arm_edge >= 0 && m >= arm_edge - 1 && b0(m) == 1 && b0(m-1) == 0
                && m >= last_acc + 2 + DEAD_CYC) begin
                last_acc = m;
                p.edge_n = m + 3;
                p.word   = {CNT_W'(cv_h[m]), FINE_W'(pc_h[m])};
                pend_q.push_back(p);
            end
            if (!en) begin
                arm_edge = -1;
                last_acc = -1000;
            end else if (arm_edge < 0 && b0(n-2) == 0)
                arm_edge = n;
            mcnt = en ? (mcnt + 1) % (1 << CNT_W) : 0;
            if (!en) movf = 0;
        end
        n_edge++;
    end

    // ------------------------------------------------------------------
    // Monitor: the head word must match the scoreboard whenever presented
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (seen_rst && m_valid) begin
            if (sb_q.size() == 0)
                chk("unexpected_word", m_data, 0);
            else begin
                chk("m_data", m_data, sb_q[0]);
                if (m_ready) begin
                    popped.push_back(m_data);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic pulse_hit(input int gap);
        taps = '0;
        taps[0] = 1'b1;
        tick();
        taps = '0;
        idle(gap);
    endtask

    logic [TAPS-1:0] pats[3];
    int              pfine[3];
    int              base, exp_c;
    logic [W-1:0]    wa, wb;
    logic [63:0]     r64;
    bit              s4[11];

    initial begin
        rst_n = 1'b0; en = 1'b0; taps = '0; m_ready = 1'b0;
        idle(3);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; en = 1'b1; m_ready = 1'b1;

        // Scenario 1: thermometer of 23, then all ones; latency E+3
        idle(10);
        exp_c = mcnt;
        taps = 56'h7F_FFFF;
        tick();                     // capture edge E
        taps = '1;
        idle(2);                    // E+2
        chk("s1_not_yet", m_valid, 0);
        tick();                     // E+3
        chk("s1_valid", m_valid, 1);
        chk("s1_fine", m_data[FINE_W-1:0], 23);
        chk("s1_coarse", m_data[W-1:FINE_W], exp_c);
        idle(3);
        taps = '0;

        // Scenario 2: bubble, all ones, first tap only
        pats[0] = 56'h0F7; pats[1] = '1; pats[2] = 56'h1;
        pfine[0] = 7; pfine[1] = 56; pfine[2] = 1;
        for (int i = 0; i < 3; i++) begin
            idle(8);
            taps = pats[i];
            tick();
            taps = '0;
            idle(8);
            wa = popped[popped.size()-1];
            chk("s2_fine", wa[FINE_W-1:0], pfine[i]);
        end

        // Scenario 3: stall, 5 hits, 5th dropped; en=0 clears ovf and drains
        m_ready = 1'b0;
        base = popped.size();
        for (int i = 0; i < 5; i++) pulse_hit(7);
        idle(4);
        chk("s3_ovf", ovf, 1);
        chk("s3_valid", m_valid, 1);
        en = 1'b0;
        tick();
        chk("s3_ovf_clr", ovf, 0);
        m_ready = 1'b1;
        idle(6);
        chk("s3_drained", popped.size() - base, 4);
        chk("s3_empty", m_valid, 0);
        en = 1'b1;
        idle(6);

        // Scenario 4: edges inside DEAD ignored; DEAD extends while q2[0] high
        base = popped.size();
        s4 = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            taps = '0;
            taps[0] = s4[i];
            tick();
        end
        taps = '0;
        idle(8);
        chk("s4_words", popped.size() - base, 2);

        // Scenario 5: coarse wrap 14 -> 2
        for (int k = 0; k < 40 && mcnt != 14; k++) tick();
        pulse_hit(5);
        for (int k = 0; k < 40 && mcnt != 2; k++) tick();
        pulse_hit(8);
        wa = popped[popped.size()-2];
        wb = popped[popped.size()-1];
        chk("s5_c14", wa[W-1:FINE_W], 14);
        chk("s5_c2", wb[W-1:FINE_W], 2);

        // Scenario 5b: write into a full FIFO with a simultaneous pop
        m_ready = 1'b0;
        base = popped.size();
        for (int i = 0; i < 4; i++) pulse_hit(7);
        taps = 56'h3;
        tick();                     // E
        taps = '0;
        idle(2);                    // E+2
        m_ready = 1'b1;
        tick();                     // E+3: push and pop together
        m_ready = 1'b0;
        idle(3);
        chk("s5_no_ovf", ovf, 0);
        m_ready = 1'b1;
        idle(8);
        chk("s5_all_words", popped.size() - base, 5);

        // Scenario 6: reset during ENCODE, taps held high after release
        idle(4);
        base = popped.size();
        taps = '1;
        idle(3);                    // E+2, FSM now in ENCODE
        rst_n = 1'b0;
        tick();
        chk("s6_valid", m_valid, 0);
        chk("s6_busy", busy, 0);
        rst_n = 1'b1;
        idle(8);
        chk("s6_no_arm", popped.size() - base, 0);
        chk("s6_idle_busy", busy, 0);
        taps = '0;
        idle(3);
        pulse_hit(8);
        chk("s6_rearm", popped.size() - base, 1);

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: taps = '0;
                    1: taps = {TAPS{1'b1}} >> $urandom_range(0, TAPS);
                    2: begin r64 = {$urandom, $urandom}; taps = r64[TAPS-1:0]; end
                    default: taps = ~({TAPS{1'b1}} >> $urandom_range(1, TAPS));
                endcase
            end
            m_ready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 59) != 0);
            tick();
        end

        // Drain
        en = 1'b1; taps = '0; m_ready = 1'b1;
        for (int k = 0; k < 60 && (sb_q.size() > 0 || pend_q.size() > 0 || m_valid); k++) tick();
        chk("drain_valid", m_valid, 0);
        chk("drain_left", sb_q.size() + pend_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
